// File: rtl/w_buf_loader.sv
// Weight-buffer write loader: packs COL stream words per row, commits rows into a
// DEPTH-row store, and serves rows on a registered read port (read-before-write).
module w_buf_loader #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int COL        = 10,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   load_base,
    input  logic [ADDR_WIDTH:0]     load_rows,
    input  logic                    s_valid,
    input  logic [WIDTH-1:0]        s_data,
    output logic                    s_ready,
    output logic                    busy,
    output logic                    done,
    input  logic                    en,
    input  logic [ADDR_WIDTH-1:0]   addr,
    output logic [WIDTH*COL-1:0]    dout
);

    localparam int ROWW = WIDTH * COL;
    localparam int CW   = (COL > 1) ? $clog2(COL) : 1;

    localparam logic [ADDR_WIDTH:0]   ROWS_MAX = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ROWS_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [CW-1:0]         COL_ONE  = CW'(1);
    localparam logic [CW-1:0]         COL_LAST = CW'(COL - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                  state;
    state_t                  next_state;

    logic [ROWW-1:0]         mem [DEPTH];
    logic [ROWW-WIDTH-1:0]   row_reg;
    logic [ROWW-1:0]         row_next;
    logic [CW-1:0]           col_cnt;
    logic [ADDR_WIDTH:0]     rows_left;
    logic [ADDR_WIDTH-1:0]   row_ptr;

    logic                    accept;
    logic                    hs;
    logic                    last_col;
    logic                    commit;

    // Oldest word ends up in the top lane once COL words have been shifted in.
    assign row_next = {row_reg, s_data};
    assign last_col = (col_cnt == COL_LAST);

    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        hs         = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (load_rows == '0) begin
                        next_state = DONE;
                    end else begin
                        accept     = 1'b1;
                        next_state = LOAD;
                    end
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                hs      = s_valid;
                if (s_valid && last_col) begin
                    commit = 1'b1;
                    if (rows_left == ROWS_ONE) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            row_reg   <= '0;
            col_cnt   <= '0;
            rows_left <= '0;
            row_ptr   <= '0;
        end else if (accept) begin
            row_ptr   <= load_base;
            rows_left <= (load_rows > ROWS_MAX) ? ROWS_MAX : load_rows;
            col_cnt   <= '0;
        end else if (hs) begin
            row_reg <= row_next[ROWW-WIDTH-1:0];
            if (last_col) begin
                col_cnt   <= '0;
                rows_left <= rows_left - ROWS_ONE;
                row_ptr   <= row_ptr + PTR_ONE;
            end else begin
                col_cnt <= col_cnt + COL_ONE;
            end
        end
    end

    // Store has no reset so committed rows survive a mid-load reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[row_ptr] <= row_next;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            dout <= '0;
        end else if (en) begin
            dout <= mem[addr];
        end else begin
            dout <= '0;
        end
    end

endmodule

// File: tb/tb_w_buf_loader.sv
// Directed self-checking bench for w_buf_loader: packing, handshake pacing, wrap,
// clamping, mid-load reset, ignored starts and read-before-write.
module tb_w_buf_loader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int COL   = 10;
    localparam int AW    = 4;
    localparam int ROWW  = WIDTH * COL;

    logic              clk;
    logic              rst_i;
    logic              start;
    logic [AW-1:0]     load_base;
    logic [AW:0]       load_rows;
    logic              s_valid;
    logic [WIDTH-1:0]  s_data;
    logic              s_ready;
    logic              busy;
    logic              done;
    logic              en;
    logic [AW-1:0]     addr;
    logic [ROWW-1:0]   dout;

    int vectors;
    int errors;
    int cyc;

    w_buf_loader #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .COL(COL),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst_i(rst_i),
        .start(start),
        .load_base(load_base),
        .load_rows(load_rows),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .busy(busy),
        .done(done),
        .en(en),
        .addr(addr),
        .dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [ROWW-1:0] obs, input logic [ROWW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Row whose first word is 'first': word k sits in lane COL-1-k.
    function automatic logic [ROWW-1:0] mkrow(input int first);
        logic [ROWW-1:0] r;
        r = '0;
        for (int k = 0; k < COL; k++) begin
            r[WIDTH*(COL-1-k) +: WIDTH] = WIDTH'(first + k);
        end
        return r;
    endfunction

    task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] rows);
        load_base = base;
        load_rows = rows;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        en   = 1'b1;
        addr = a;
        tick();
        en   = 1'b0;
    endtask

    // Streams nwords words (optionally every other cycle) until done or a cycle bound.
    task automatic stream(input int first, input int nwords, input bit toggle,
                          input int spur_at, output int cycles);
        int k;
        bit hs;
        k = 0;
        cycles = 0;
        while (done !== 1'b1 && cycles < 400) begin
            s_valid = (k < nwords) && (!toggle || (cycles % 2 == 0));
            s_data  = WIDTH'(first + k);
            start   = (cycles == spur_at);
            if (start) begin
                load_base = 4'd9;
                load_rows = 5'd3;
            end
            hs = s_valid && s_ready;
            tick();
            cycles++;
            if (hs) k++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic end_checks(input string tag, input int cycles, input int exp_cycles);
        chk({tag, "_done"}, ROWW'(done), ROWW'(1'b1));
        chk({tag, "_cycles"}, ROWW'(cycles), ROWW'(exp_cycles));
        chk({tag, "_busy_at_done"}, ROWW'(busy), ROWW'(1'b0));
        chk({tag, "_ready_at_done"}, ROWW'(s_ready), ROWW'(1'b0));
    endtask

    initial begin
        vectors   = 0;
        errors    = 0;
        rst_i     = 1'b1;
        start     = 1'b0;
        load_base = '0;
        load_rows = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        en        = 1'b1;
        addr      = 4'd3;

        // Reset holds every output low even with a read enabled
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_dout", dout, '0);
            chk("rst_s_ready", ROWW'(s_ready), '0);
            chk("rst_busy", ROWW'(busy), '0);
            chk("rst_done", ROWW'(done), '0);
        end
        rst_i = 1'b0;
        en    = 1'b0;
        tick();

        // Back-to-back two-row load into rows 0..1
        do_start(4'd0, 5'd2);
        chk("b2b_ready_after_start", ROWW'(s_ready), ROWW'(1'b1));
        chk("b2b_busy_after_start", ROWW'(busy), ROWW'(1'b1));
        stream(32'h00, 20, 1'b0, -1, cyc);
        end_checks("b2b", cyc, 20);
        tick();
        chk("b2b_done_one_cycle", ROWW'(done), '0);
        rd(4'd0);
        chk("b2b_row0", dout, mkrow(32'h00));
        chk("b2b_row0_lane9", ROWW'(dout[ROWW-1 -: WIDTH]), ROWW'(32'h00));
        chk("b2b_row0_lane0", ROWW'(dout[WIDTH-1:0]), ROWW'(32'h09));
        rd(4'd1);
        chk("b2b_row1_lane9", ROWW'(dout[ROWW-1 -: WIDTH]), ROWW'(32'h0A));
        chk("b2b_row1_lane0", ROWW'(dout[WIDTH-1:0]), ROWW'(32'h13));
        tick();
        chk("en_low_dout_zero", dout, '0);

        // Same data with s_valid toggling, placed at rows 4..5
        do_start(4'd4, 5'd2);
        stream(32'h00, 20, 1'b1, -1, cyc);
        end_checks("tog", cyc, 39);
        tick();
        rd(4'd4);
        chk("tog_row4", dout, mkrow(32'h00));
        rd(4'd5);
        chk("tog_row5", dout, mkrow(32'h0A));

        // Wrap from row 15 to row 0
        do_start(4'd15, 5'd2);
        stream(32'h200, 20, 1'b0, -1, cyc);
        end_checks("wrap", cyc, 20);
        tick();
        rd(4'd15);
        chk("wrap_row15", dout, mkrow(32'h200));
        rd(4'd0);
        chk("wrap_row0", dout, mkrow(32'h20A));
        rd(4'd1);
        chk("wrap_row1_kept", dout, mkrow(32'h0A));
        rd(4'd4);
        chk("wrap_row4_kept", dout, mkrow(32'h00));

        // Reset after 15 words of a two-row load at row 0
        do_start(4'd0, 5'd2);
        for (int k = 0; k < 15; k++) begin
            s_valid = 1'b1;
            s_data  = WIDTH'(32'h300 + k);
            tick();
        end
        s_valid = 1'b0;
        en      = 1'b1;
        addr    = 4'd0;
        rst_i   = 1'b1;
        #1;
        chk("mid_rst_ready", ROWW'(s_ready), '0);
        chk("mid_rst_busy", ROWW'(busy), '0);
        chk("mid_rst_done", ROWW'(done), '0);
        tick();
        chk("mid_rst_dout", dout, '0);
        rst_i = 1'b0;
        en    = 1'b0;
        tick();
        rd(4'd0);
        chk("mid_rst_row0", dout, mkrow(32'h300));
        rd(4'd1);
        chk("mid_rst_row1_kept", dout, mkrow(32'h0A));
        do_start(4'd6, 5'd1);
        chk("post_rst_busy", ROWW'(busy), ROWW'(1'b1));
        stream(32'h400, 10, 1'b0, -1, cyc);
        end_checks("post_rst", cyc, 10);
        tick();
        rd(4'd6);
        chk("post_rst_row6", dout, mkrow(32'h400));

        // Zero-row load: done next cycle, busy never set, nothing written
        do_start(4'd6, 5'd0);
        chk("zero_done", ROWW'(done), ROWW'(1'b1));
        chk("zero_busy", ROWW'(busy), '0);
        tick();
        chk("zero_done_cleared", ROWW'(done), '0);
        rd(4'd6);
        chk("zero_row6_kept", dout, mkrow(32'h400));

        // load_rows=20 clamps to 16 rows starting at row 0
        do_start(4'd0, 5'd20);
        stream(32'h1000, 200, 1'b0, -1, cyc);
        end_checks("clamp", cyc, 160);
        tick();
        rd(4'd0);
        chk("clamp_row0", dout, mkrow(32'h1000));
        rd(4'd7);
        chk("clamp_row7", dout, mkrow(32'h1000 + 70));
        rd(4'd15);
        chk("clamp_row15", dout, mkrow(32'h1000 + 150));

        // start pulses during LOAD and during DONE are ignored
        do_start(4'd8, 5'd1);
        stream(32'h2000, 10, 1'b0, 3, cyc);
        end_checks("spur", cyc, 10);
        load_rows = 5'd0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chk("spur_done_ignored", ROWW'(done), '0);
        chk("spur_busy_ignored", ROWW'(busy), '0);
        tick();
        chk("spur_idle_done", ROWW'(done), '0);
        rd(4'd8);
        chk("spur_row8", dout, mkrow(32'h2000));
        rd(4'd9);
        chk("spur_row9_kept", dout, mkrow(32'h1000 + 90));

        // Read of the committing row in its commit cycle returns old contents
        do_start(4'd10, 5'd1);
        for (int k = 0; k < 10; k++) begin
            s_valid = 1'b1;
            s_data  = WIDTH'(32'h3000 + k);
            if (k == 9) begin
                en   = 1'b1;
                addr = 4'd10;
            end
            tick();
        end
        s_valid = 1'b0;
        chk("rbw_done", ROWW'(done), ROWW'(1'b1));
        chk("rbw_old_data", dout, mkrow(32'h1000 + 100));
        tick();
        chk("rbw_new_data", dout, mkrow(32'h3000));
        en = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/w_buf_loader.md
# w_buf_loader

Write-side companion to the weight buffer. It accepts a stream of WIDTH-bit weight words over a valid/ready handshake and packs each COL consecutive words into one row. It commits each full row into an internal DEPTH-row store, and serves rows on a registered read port with the same packing and enable semantics the PE array's weight buffer read path already uses. This lets the accelerator reload weights at run time instead of relying only on file initialisation.

## Interface
- WIDTH, 32, bits per weight word
- DEPTH, 16, rows in the store; must be a power of two
- COL, 10, words per row
- ADDR_WIDTH, $clog2(DEPTH), row address width
- clk  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse that begins a load; ignored unless idle
- load_base  in  ADDR_WIDTH  first row to write, sampled on start
- load_rows  in  ADDR_WIDTH+1  number of rows to load, sampled on start
- s_valid  in  1  stream word valid
- s_data  in  WIDTH  stream word
- s_ready  out  1  loader accepts a word this cycle
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when a load finishes
- en  in  1  read enable
- addr  in  ADDR_WIDTH  read row
- dout  out  WIDTH*COL  registered read row

## Operation
- Store: mem[0:DEPTH-1], each WIDTH*COL bits. Contents are not cleared by reset; power-up contents are undefined.
- FSM has three states: IDLE, LOAD, DONE.
- IDLE:
  - start with load_rows==0 goes to DONE and writes nothing.
  - start with load_rows>DEPTH clamps the row count to DEPTH.
  - Any other start latches load_base into row_ptr and load_rows into rows_left, clears col_cnt, and goes to LOAD.
- LOAD:
  - s_ready=1. A handshake is a cycle where s_valid and s_ready are both 1.
  - On each handshake: row_reg <= {row_reg[WIDTH*(COL-1)-1:0], s_data}, and col_cnt increments.
  - On the handshake with col_cnt==COL-1: write {row_reg[WIDTH*(COL-1)-1:0], s_data} to mem[row_ptr] in that same cycle. Then clear col_cnt, decrement rows_left, and advance row_ptr by 1 modulo DEPTH (row DEPTH-1 wraps to 0).
  - If rows_left was 1 at that handshake, go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- start while in LOAD or DONE is ignored, with no side effects.
- Row packing:
  - The first word of a row lands in lane COL-1, i.e. dout[WIDTH*COL-1 -: WIDTH].
  - The last word lands in lane 0, i.e. dout[WIDTH-1:0].
  - In general, lane i holds column COL-1-i.
- Read port, evaluated every cycle independently of the FSM:
  - en=1: dout <= mem[addr].
  - en=0: dout <= 0.
- Read and commit on the same row in the same cycle: dout returns the old contents (read-before-write).
- Reset mid-load:
  - Returns to IDLE and discards the partial row.
  - Rows committed before reset are kept.

## Timing
- Reset values: s_ready=0, busy=0, done=0, dout=0, state=IDLE, col_cnt=0, rows_left=0, row_ptr=0, row_reg=0.
- s_ready and busy are decoded from the state register only. They do not depend on s_valid.
- start sampled at edge N puts s_ready=1 and busy=1 from cycle N+1.
- Throughput is one word per cycle. s_valid may drop at any time and the loader simply waits.
- A row commits at the edge of its last handshake. A read of that row issued in the next cycle returns the new data one edge later (read latency is 1 cycle).
- For the last row's handshake at edge M: in cycle M+1, done=1, busy=0 and s_ready=0. In cycle M+2, the loader is IDLE and a new start is accepted.
- A start with load_rows==0 produces done in the cycle after start, with busy staying 0.

## Test plan
- Reset, then en=1, addr=3 → dout stays 0 while rst_i=1; s_ready=0, busy=0 and done=0 throughout.
- start with load_base=0, load_rows=2; stream words 0x00..0x13 back-to-back → 20 handshakes and one done pulse. Then a read of row 0 gives lane 9=0x00 and lane 0=0x09; a read of row 1 gives lane 9=0x0A and lane 0=0x13.
- Same load as above but s_valid toggles 1/0 every cycle → identical memory contents; done arrives 19 cycles later than in the back-to-back case.
- start with load_base=15, load_rows=2 → rows land at 15 then 0 (wrap-around); rows 1–14 are unchanged.
- Assert rst_i after 15 words of a 2-row load → row 0 holds words 0–9, row 1 keeps its old value, outputs return to reset values, and a new start succeeds.
- load_rows=0 → done in the next cycle, no writes. load_rows=20 → exactly 16 rows are written. start during LOAD → ignored. Read of row_ptr on its commit cycle → old data.
